// File: rtl/spi_master_ctrl.sv
// SPI mode-0 master, one DATA_W-bit MSB-first transfer per start; optional SPI_LOOPBACK_EN adds a loopback input.
// Latency 1+(2*DATA_W+1)*CLK_DIV cycles from accept to done; start is ignored (not queued) while busy or done.
module spi_master_ctrl #(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
`ifdef SPI_LOOPBACK_EN
  input  logic              loopback,
`endif
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  output logic              ss,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(DATA_W) + 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_SHIFT = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
  logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              sclk_q, sclk_d;
  logic              ss_q, ss_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              div_end;
  logic              ser_in;

  // mosi is the MSB of the transmit shifter, so it holds the LSB once shifting stops.
`ifdef SPI_LOOPBACK_EN
  logic lb_q, lb_d;
  assign ser_in = lb_q ? tx_sh_q[DATA_W-1] : miso;
`else
  assign ser_in = miso;
`endif

  assign div_end = (div_q == DIV_LAST);

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    bit_d     = bit_q;
    tx_sh_d   = tx_sh_q;
    rx_sh_d   = rx_sh_q;
    rx_data_d = rx_data_q;
    sclk_d    = sclk_q;
    ss_d      = ss_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
`ifdef SPI_LOOPBACK_EN
    lb_d      = lb_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SETUP;
          ss_d    = 1'b0;
          busy_d  = 1'b1;
          tx_sh_d = tx_data;
          div_d   = '0;
          bit_d   = '0;
`ifdef SPI_LOOPBACK_EN
          lb_d    = loopback;
`endif
        end
      end
      ST_SETUP: begin
        if (div_end) begin
          div_d   = '0;
          state_d = ST_SHIFT;
          sclk_d  = 1'b1;
          rx_sh_d = {rx_sh_q[DATA_W-2:0], ser_in};
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      ST_SHIFT: begin
        if (div_end) begin
          div_d = '0;
          if (sclk_q) begin
            sclk_d = 1'b0;
            if (bit_q == BIT_LAST) begin
              state_d = ST_HOLD;
            end else begin
              bit_d   = bit_q + 1'b1;
              tx_sh_d = tx_sh_q << 1;
            end
          end else begin
            sclk_d  = 1'b1;
            rx_sh_d = {rx_sh_q[DATA_W-2:0], ser_in};
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      ST_HOLD: begin
        if (div_end) begin
          div_d     = '0;
          state_d   = ST_DONE;
          ss_d      = 1'b1;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          rx_data_d = rx_sh_q;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      div_q     <= '0;
      bit_q     <= '0;
      tx_sh_q   <= '0;
      rx_sh_q   <= '0;
      rx_data_q <= '0;
      sclk_q    <= 1'b0;
      ss_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef SPI_LOOPBACK_EN
      lb_q      <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
      tx_sh_q   <= tx_sh_d;
      rx_sh_q   <= rx_sh_d;
      rx_data_q <= rx_data_d;
      sclk_q    <= sclk_d;
      ss_q      <= ss_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef SPI_LOOPBACK_EN
      lb_q      <= lb_d;
`endif
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign rx_data = rx_data_q;
  assign ss      = ss_q;
  assign sclk    = sclk_q;
  assign mosi    = tx_sh_q[DATA_W-1];

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: CLK_DIV=2 instance with a mode-0 slave model, plus a CLK_DIV=1 instance for timing.
module tb_spi_master_ctrl;
  localparam int D     = 2;
  localparam int TDONE = 1 + 17 * D;

  typedef struct {
    logic [7:0] tx;
    logic [7:0] slv;
    logic [7:0] exp_rx;
  } vec_t;

  logic       clk, rst;
  logic       start, busy, done, ss, sclk, mosi, miso;
  logic [7:0] tx_data, rx_data;
  logic       start_b, busy_b, done_b, ss_b, sclk_b, mosi_b, miso_b;
  logic [7:0] tx_b, rx_b;
`ifdef SPI_LOOPBACK_EN
  logic       lb;
`endif

  int         checks = 0;
  int         errors = 0;
  logic [7:0] slave_word = 8'h00;
  int         sidx = 0;
  logic       s_prev_sclk = 1'b0;
  logic [7:0] model_rx;
  vec_t       vecs[10];

  spi_master_ctrl #(.DATA_W(8), .CLK_DIV(D)) u_a (
    .clk(clk), .rst(rst), .start(start), .tx_data(tx_data),
`ifdef SPI_LOOPBACK_EN
    .loopback(lb),
`endif
    .busy(busy), .done(done), .rx_data(rx_data), .ss(ss), .sclk(sclk), .mosi(mosi), .miso(miso)
  );

  spi_master_ctrl #(.DATA_W(8), .CLK_DIV(1)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .tx_data(tx_b),
`ifdef SPI_LOOPBACK_EN
    .loopback(1'b0),
`endif
    .busy(busy_b), .done(done_b), .rx_data(rx_b), .ss(ss_b), .sclk(sclk_b), .mosi(mosi_b), .miso(miso_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Mode-0 slave: presents MSB when selected, advances one bit after each sclk fall.
  always @(negedge clk) begin
    if (ss) sidx = 0;
    else if (s_prev_sclk && !sclk) sidx = sidx + 1;
    s_prev_sclk = sclk;
  end
  assign miso = (sidx < 8) ? slave_word[7 - sidx] : 1'b0;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
    end
  endtask

  // Follows one transfer of u_a from the accept cycle (called at negedge of cycle 0).
  task automatic watch(input bit keep_start, output int done_n, output logic [7:0] mbits,
                       output int rises, output int werr);
    logic prev;
    logic exp_sclk;
    prev = 1'b0; done_n = -1; mbits = 8'h00; rises = 0; werr = 0;
    for (int n = 1; n <= TDONE + 4 && done_n < 0; n++) begin
      @(negedge clk);
      if (!keep_start) begin
        start   = 1'b0;
        tx_data = 8'($urandom);
      end
      if (sclk && !prev) begin
        if (rises < 8) mbits[7 - rises] = mosi;
        rises++;
      end
      prev = sclk;
      if (n < TDONE) begin
        exp_sclk = (((n - 1) / D) % 2) == 1;
        if ({ss, busy, done, sclk} !== {1'b0, 1'b1, 1'b0, exp_sclk}) werr++;
        if (rx_data !== model_rx) werr++;
      end else if (n == TDONE) begin
        if ({ss, busy, done, sclk} !== 4'b1010) werr++;
      end
      if (done) done_n = n;
    end
  endtask

  task automatic do_xfer(input logic [7:0] tx, input logic [7:0] slv, input logic [7:0] exp_rx);
    int dn, rises, werr;
    logic [7:0] mb;
    slave_word = slv;
    tx_data    = tx;
    start      = 1'b1;
    watch(1'b0, dn, mb, rises, werr);
    chk("done_cycle", dn, TDONE);
    chk("mosi_bits", mb, tx);
    chk("sclk_rises", rises, 8);
    chk("waveform", werr, 0);
    chk("rx_data", rx_data, exp_rx);
    model_rx = exp_rx;
    @(negedge clk);
    chk("after_done", {busy, done, ss, rx_data}, {3'b001, model_rx});
  endtask

  initial begin
    int dn, rises, werr, n, cnt, hi, sserr, sclkerr, dnb;
    logic [7:0] mb;
    logic prev;
    rst = 1'b1; start = 1'b0; tx_data = 8'h00; start_b = 1'b0; tx_b = 8'h00; miso_b = 1'b1;
    model_rx = 8'h00;
`ifdef SPI_LOOPBACK_EN
    lb = 1'b0;
`endif
    // Reset state and 50-cycle hold
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_outputs", {ss, sclk, mosi, busy, done, rx_data}, {5'b10000, 8'h00});
    rst = 1'b0;
    werr = 0;
    repeat (50) begin
      @(negedge clk);
      if ({ss, sclk, mosi, busy, done, rx_data} !== {5'b10000, 8'h00}) werr++;
      if ({ss_b, sclk_b, mosi_b, busy_b, done_b, rx_b} !== {5'b10000, 8'h00}) werr++;
    end
    chk("rst_hold", werr, 0);

    // Basic transfer
    do_xfer(8'hA5, 8'h3C, 8'h3C);

    // Vector table: fixed corners then random words
    vecs[0] = '{8'h00, 8'hFF, 8'hFF};
    vecs[1] = '{8'hFF, 8'h00, 8'h00};
    vecs[2] = '{8'h81, 8'h7E, 8'h7E};
    vecs[3] = '{8'h01, 8'h80, 8'h80};
    for (int i = 4; i < 10; i++) begin
      vecs[i].tx     = 8'($urandom);
      vecs[i].slv    = 8'($urandom);
      vecs[i].exp_rx = vecs[i].slv;
    end
    for (int i = 0; i < 10; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      do_xfer(vecs[i].tx, vecs[i].slv, vecs[i].exp_rx);
    end

    // Back-to-back with start held high throughout
    slave_word = 8'h3C; tx_data = 8'h81; start = 1'b1;
    watch(1'b1, dn, mb, rises, werr);
    chk("b2b_done1", dn, TDONE);
    chk("b2b_mosi1", mb, 8'h81);
    chk("b2b_wave1", werr, 0);
    chk("b2b_rx1", rx_data, 8'h3C);
    model_rx = 8'h3C;
    tx_data = 8'h7E; slave_word = 8'hC3;
    @(negedge clk);
    chk("b2b_gap", {ss, busy, done}, 3'b100);
    watch(1'b1, dn, mb, rises, werr);
    start = 1'b0;
    chk("b2b_done2", dn, TDONE);
    chk("b2b_mosi2", mb, 8'h7E);
    chk("b2b_wave2", werr, 0);
    chk("b2b_rx2", rx_data, 8'hC3);
    model_rx = 8'hC3;
    @(negedge clk);

    // Reset after the 4th sclk rise
    slave_word = 8'h55; tx_data = 8'hFF; start = 1'b1;
    rises = 0; n = 0; prev = 1'b0;
    while (rises < 4 && n < 100) begin
      @(negedge clk);
      n++;
      start = 1'b0;
      if (sclk && !prev) rises++;
      prev = sclk;
    end
    chk("rst_mid_cycle", n, 1 + 7 * D);
    rst = 1'b1;
    #1;
    chk("rst_mid_outputs", {ss, sclk, mosi, busy, done, rx_data}, {5'b10000, 8'h00});
    model_rx = 8'h00;
    cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) cnt++;
    end
    chk("rst_mid_no_done", cnt, 0);
    rst = 1'b0;
    @(negedge clk);
    do_xfer(8'hFF, 8'h55, 8'h55);

    // CLK_DIV=1 timing on u_b (miso tied high)
    tx_b = 8'h3C; start_b = 1'b1;
    hi = 0; sserr = 0; sclkerr = 0; dnb = -1; cnt = 0; mb = 8'h00;
    for (int k = 1; k <= 22; k++) begin
      @(negedge clk);
      start_b = 1'b0; tx_b = 8'h00;
      if (ss_b !== ((k <= 17) ? 1'b0 : 1'b1)) sserr++;
      if (sclk_b !== ((k >= 2 && k <= 16 && (k % 2) == 0) ? 1'b1 : 1'b0)) sclkerr++;
      if (sclk_b) begin
        if (hi < 8) mb[7 - hi] = mosi_b;
        hi++;
      end
      if (done_b) begin
        cnt++;
        if (dnb < 0) dnb = k;
      end
    end
    chk("b_done_cycle", dnb, 18);
    chk("b_done_count", cnt, 1);
    chk("b_sclk_pulses", hi, 8);
    chk("b_sclk_shape", sclkerr, 0);
    chk("b_ss_window", sserr, 0);
    chk("b_mosi", mb, 8'h3C);
    chk("b_rx", rx_b, 8'hFF);

`ifdef SPI_LOOPBACK_EN
    lb = 1'b1;
    do_xfer(8'h5A, 8'h00, 8'h5A);
    lb = 1'b0;
    do_xfer(8'h5A, 8'h00, 8'h00);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
